// File: rtl/dmi_arb_pkg.sv
// dmi_arb_pkg
// Shared types for the DMI arbiter:
//   dmi_op_e     - DMI request opcode (nop/read/write)
//   dmi_resp_e   - DMI response code (ok/failed/busy)
//   arb_state_e  - arbiter control states
//   idx_width()  - width of an index/counter that must hold values 0..n-1,
//                  never narrower than one bit
package dmi_arb_pkg;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_RESP_OK     = 2'd0,
        DMI_RESP_FAILED = 2'd2,
        DMI_RESP_BUSY   = 2'd3
    } dmi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker: the first requester at or after
// ptr (wrapping modulo N) wins.
// Ports:
//   req       in  N   request vector
//   ptr       in  PW  highest-priority index (must be < N)
//   gnt       out N   one-hot grant (zero when nobody requests)
//   gnt_idx   out PW  index of the granted requester
//   gnt_valid out 1   some requester was granted
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [PW-1:0] cand_s;

    // Scan N candidates starting at ptr; the first requesting one wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = PW'((int'(ptr) + k) % N);
            if (req[cand_s] && !gnt_valid) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = cand_s;
                gnt_valid   = 1'b1;
            end else begin
                // an earlier candidate already won, or this one is idle
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter
// Arbitrates DMI traffic from NUM_HOSTS debug transports onto one debug
// module port. One transaction in flight, round-robin grants, response
// routed to the issuing host, response timeout and per-host abort.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   host_rst_n[N]                  per-host DMI reset, low = host aborts
//   host_req_valid/ready[N]        per-host request handshake
//   host_req_addr/op/data          packed per-host request fields
//   host_resp_valid[N]/ready[N]    per-host response handshake
//   host_resp_data/code            shared response payload
//   dm_req_*                       request channel to the debug module
//   dm_resp_*                      response channel from the debug module
//   owner                          current or last granted host
//   err_timeout                    one-cycle pulse when a timeout fires
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int NUM_HOSTS      = 2,
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_HOSTS-1:0]               host_rst_n,
    input  logic [NUM_HOSTS-1:0]               host_req_valid,
    output logic [NUM_HOSTS-1:0]               host_req_ready,
    input  logic [NUM_HOSTS*ADDR_W-1:0]        host_req_addr,
    input  logic [NUM_HOSTS*2-1:0]             host_req_op,
    input  logic [NUM_HOSTS*DATA_W-1:0]        host_req_data,
    output logic [NUM_HOSTS-1:0]               host_resp_valid,
    input  logic [NUM_HOSTS-1:0]               host_resp_ready,
    output logic [DATA_W-1:0]                  host_resp_data,
    output logic [1:0]                         host_resp_code,
    output logic                               dm_req_valid,
    input  logic                               dm_req_ready,
    output logic [ADDR_W-1:0]                  dm_req_addr,
    output logic [1:0]                         dm_req_op,
    output logic [DATA_W-1:0]                  dm_req_data,
    input  logic                               dm_resp_valid,
    output logic                               dm_resp_ready,
    input  logic [DATA_W-1:0]                  dm_resp_data,
    input  logic [1:0]                         dm_resp_code,
    output logic [idx_width(NUM_HOSTS)-1:0]    owner,
    output logic                               err_timeout
);

    localparam int OW = idx_width(NUM_HOSTS);
    localparam int TW = idx_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e        state_r, state_s;
    logic [OW-1:0]     rr_ptr_r, rr_ptr_s;
    logic [OW-1:0]     owner_r, owner_s;
    logic              orphan_r, orphan_s;
    logic              abort_r, abort_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    dmi_op_e           op_r, op_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    dmi_resp_e         rcode_r, rcode_s;
    logic              err_timeout_r, err_timeout_s;

    logic [NUM_HOSTS-1:0] eligible_s;
    logic [NUM_HOSTS-1:0] gnt_s;
    logic [OW-1:0]        gnt_idx_s;
    logic                 gnt_any_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [1:0]           sel_op_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 owner_rst_n_s;
    logic                 timeout_hit_s;

    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] cur);
        if (cur == OW'(NUM_HOSTS - 1)) begin
            return '0;
        end else begin
            return cur + OW'(1);
        end
    endfunction

    // Grants only happen in IDLE, and never while a late response is pending.
    assign eligible_s = (state_r == ST_IDLE && !orphan_r) ? (host_req_valid & host_rst_n)
                                                          : '0;

    rr_arbiter #(
        .N  (NUM_HOSTS),
        .PW (OW)
    ) u_rr (
        .req       (eligible_s),
        .ptr       (rr_ptr_r),
        .gnt       (gnt_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_any_s)
    );

    assign host_req_ready = gnt_s;
    assign owner_rst_n_s  = host_rst_n[owner_r];
    assign timeout_hit_s  = (TIMEOUT_CYCLES != 0) && (timer_r == TMAX);

    // One-hot AND-OR mux of the granted host's request fields.
    always_comb begin
        sel_addr_s = '0;
        sel_op_s   = 2'd0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            sel_addr_s = sel_addr_s | (host_req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[i]}});
            sel_op_s   = sel_op_s   | (host_req_op[i*2 +: 2]             & {2{gnt_s[i]}});
            sel_data_s = sel_data_s | (host_req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
        end
    end

    // Next-state, timer and datapath register updates.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        owner_s       = owner_r;
        orphan_s      = orphan_r;
        abort_s       = abort_r;
        timer_s       = timer_r;
        addr_s        = addr_r;
        op_s          = op_r;
        wdata_s       = wdata_r;
        rdata_s       = rdata_r;
        rcode_s       = rcode_r;
        err_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (orphan_r) begin
                    // swallow the late response of a timed-out transaction
                    if (dm_resp_valid) begin
                        orphan_s = 1'b0;
                    end else begin
                        orphan_s = 1'b1;
                    end
                end else if (gnt_any_s) begin
                    owner_s = gnt_idx_s;
                    addr_s  = sel_addr_s;
                    op_s    = dmi_op_e'(sel_op_s);
                    wdata_s = sel_data_s;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // the request cannot be withdrawn, so an abort only marks it
                if (!owner_rst_n_s) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_r;
                end
                if (dm_req_ready) begin
                    state_s = ST_WAIT;
                    timer_s = '0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                timer_s = timer_r + TW'(1);
                if (dm_resp_valid) begin
                    if (abort_r || !owner_rst_n_s) begin
                        state_s  = ST_IDLE;
                        rr_ptr_s = next_ptr(owner_r);
                    end else begin
                        rdata_s = dm_resp_data;
                        rcode_s = dmi_resp_e'(dm_resp_code);
                        state_s = ST_RESP;
                    end
                end else if (timeout_hit_s) begin
                    err_timeout_s = 1'b1;
                    orphan_s      = 1'b1;
                    rdata_s       = '0;
                    rcode_s       = DMI_RESP_FAILED;
                    if (abort_r) begin
                        state_s  = ST_IDLE;
                        rr_ptr_s = next_ptr(owner_r);
                    end else begin
                        state_s = ST_RESP;
                    end
                end else if (!abort_r && !owner_rst_n_s) begin
                    abort_s = 1'b1;
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (!owner_rst_n_s || host_resp_ready[owner_r]) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = next_ptr(owner_r);
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                // the timer keeps running so a dead DM cannot hold us here
                timer_s = timer_r + TW'(1);
                if (dm_resp_valid) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = next_ptr(owner_r);
                end else if (timeout_hit_s) begin
                    err_timeout_s = 1'b1;
                    orphan_s      = 1'b1;
                    state_s       = ST_IDLE;
                    rr_ptr_s      = next_ptr(owner_r);
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            orphan_r      <= 1'b0;
            abort_r       <= 1'b0;
            timer_r       <= '0;
            addr_r        <= '0;
            op_r          <= DMI_OP_NOP;
            wdata_r       <= '0;
            rdata_r       <= '0;
            rcode_r       <= DMI_RESP_OK;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            owner_r       <= owner_s;
            orphan_r      <= orphan_s;
            abort_r       <= abort_s;
            timer_r       <= timer_s;
            addr_r        <= addr_s;
            op_r          <= op_s;
            wdata_r       <= wdata_s;
            rdata_r       <= rdata_s;
            rcode_r       <= rcode_s;
            err_timeout_r <= err_timeout_s;
        end
    end

    // Response-valid decode from the registered state and owner.
    always_comb begin
        host_resp_valid = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            host_resp_valid[i] = (state_r == ST_RESP) && (owner_r == OW'(i));
        end
    end

    assign dm_req_valid   = (state_r == ST_REQ);
    assign dm_resp_ready  = (state_r == ST_WAIT) || (state_r == ST_DRAIN) ||
                            ((state_r == ST_IDLE) && orphan_r);
    assign dm_req_addr    = addr_r;
    assign dm_req_op      = op_r;
    assign dm_req_data    = wdata_r;
    assign host_resp_data = rdata_r;
    assign host_resp_code = rcode_r;
    assign owner          = owner_r;
    assign err_timeout    = err_timeout_r;

endmodule
